// File: rtl/game_pkg.sv
// Shared game definitions: position width and range defaults (also used for
// the game core's holepos), counter widths and the player FSM state encoding.
package game_pkg;

    localparam int unsigned POS_W         = 4;
    localparam int unsigned POS_MIN_DEF   = 0;
    localparam int unsigned POS_MAX_DEF   = 15;
    localparam int unsigned POS_RESET_DEF = 8;

    localparam int unsigned DB_CNT_W = 4;
    localparam int unsigned RCNT_W   = 10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } plr_state_e;

endpackage

// File: rtl/player_ctrl_if.sv
// Board-side bundle of the player controller: tick strobe, raw buttons in,
// player position and move pulse out.
interface player_ctrl_if import game_pkg::*; ();

    logic             tick;
    logic             btn_left;
    logic             btn_right;
    logic [POS_W-1:0] plrpos;
    logic             moved;

    modport master (output tick, btn_left, btn_right, input plrpos, moved);
    modport slave  (input tick, btn_left, btn_right, output plrpos, moved);

endinterface

// File: rtl/btn_debounce.sv
// One button: 2-FF synchroniser followed by a tick-sampled debounce counter.
// The stable level flips after DB_CNT consecutive differing tick samples.
module btn_debounce import game_pkg::*; #(
    parameter int unsigned DB_CNT = 4
) (
    input  logic clk,
    input  logic clr_n,
    input  logic tick,
    input  logic btn,
    output logic stable
);

    localparam logic [DB_CNT_W-1:0] DB_CNT_C = DB_CNT_W'(DB_CNT);

    logic                sync1_q, sync1_d;
    logic                sync2_q, sync2_d;
    logic                stable_q, stable_d;
    logic [DB_CNT_W-1:0] cnt_q, cnt_d;

    // Synchroniser shift and debounce counter update
    always_comb begin
        sync1_d  = btn;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        cnt_d    = cnt_q;
        if (tick) begin
            if (sync2_q != stable_q) begin
                if (cnt_q + 1'b1 == DB_CNT_C) begin
                    stable_d = sync2_q;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end else begin
                cnt_d = '0;
            end
        end
    end

    // State registers with synchronous active-low clear
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable = stable_q;

endmodule

// File: rtl/player_ctrl.sv
// Player input controller: debounced left/right buttons step plrpos one
// column per press, saturating at POS_MIN/POS_MAX.
// Optional auto-repeat while a single button is held: PLAYER_CTRL_AUTOREPEAT_EN.
module player_ctrl import game_pkg::*; #(
    parameter int unsigned DB_CNT    = 4,
    parameter int unsigned POS_MIN   = POS_MIN_DEF,
    parameter int unsigned POS_MAX   = POS_MAX_DEF,
    parameter int unsigned POS_RESET = POS_RESET_DEF,
    parameter int unsigned RPT_DELAY = 250,
    parameter int unsigned RPT_RATE  = 50
) (
    input logic          clk,
    input logic          clr_n,
    player_ctrl_if.slave bus
);

    localparam logic [POS_W-1:0] POS_MIN_C   = POS_W'(POS_MIN);
    localparam logic [POS_W-1:0] POS_MAX_C   = POS_W'(POS_MAX);
    localparam logic [POS_W-1:0] POS_RESET_C = POS_W'(POS_RESET);

    if (DB_CNT < 1 || DB_CNT > 15) begin : g_bad_db_cnt
        $error("player_ctrl: DB_CNT out of range");
    end
    if (RPT_DELAY < 1 || RPT_DELAY > 1023 || RPT_RATE < 1 || RPT_RATE > 1023) begin : g_bad_rpt
        $error("player_ctrl: RPT_DELAY/RPT_RATE out of range");
    end
    if (POS_MIN > POS_MAX || POS_RESET < POS_MIN || POS_RESET > POS_MAX) begin : g_bad_pos
        $error("player_ctrl: position range inconsistent");
    end

    logic             stable_l, stable_r;
    logic             prev_l_q, prev_l_d;
    logic             prev_r_q, prev_r_d;
    logic [POS_W-1:0] plrpos_q, plrpos_d;
    logic             moved_q, moved_d;
    logic             press_l, press_r;
    logic             step_l, step_r;

`ifdef PLAYER_CTRL_AUTOREPEAT_EN
    localparam logic [RCNT_W-1:0] RPT_DELAY_C = RCNT_W'(RPT_DELAY);
    localparam logic [RCNT_W-1:0] RPT_RATE_C  = RCNT_W'(RPT_RATE);

    plr_state_e        state_q, state_d;
    logic              dir_left_q, dir_left_d;
    logic [RCNT_W-1:0] rcnt_q, rcnt_d;
    logic              held;
    logic [RCNT_W-1:0] rpt_limit;
`endif

    btn_debounce #(.DB_CNT(DB_CNT)) u_db_left (
        .clk    (clk),
        .clr_n  (clr_n),
        .tick   (bus.tick),
        .btn    (bus.btn_left),
        .stable (stable_l)
    );

    btn_debounce #(.DB_CNT(DB_CNT)) u_db_right (
        .clk    (clk),
        .clr_n  (clr_n),
        .tick   (bus.tick),
        .btn    (bus.btn_right),
        .stable (stable_r)
    );

    // A rising edge only counts while the other button is released
    assign press_l = stable_l & ~prev_l_q & ~stable_r;
    assign press_r = stable_r & ~prev_r_q & ~stable_l;

    // Step request (FSM when auto-repeat is built in) and saturating position update
    always_comb begin
        prev_l_d = stable_l;
        prev_r_d = stable_r;
        step_l   = 1'b0;
        step_r   = 1'b0;
        plrpos_d = plrpos_q;
        moved_d  = 1'b0;
`ifdef PLAYER_CTRL_AUTOREPEAT_EN
        state_d    = state_q;
        dir_left_d = dir_left_q;
        rcnt_d     = rcnt_q;
        held       = dir_left_q ? stable_l : stable_r;
        rpt_limit  = (state_q == DELAY) ? RPT_DELAY_C : RPT_RATE_C;
        unique case (state_q)
            IDLE: begin
                if (press_l || press_r) begin
                    step_l     = press_l;
                    step_r     = press_r;
                    dir_left_d = press_l;
                    rcnt_d     = '0;
                    state_d    = DELAY;
                end
            end
            DELAY, REPEAT: begin
                if (!held || (stable_l && stable_r)) begin
                    rcnt_d  = '0;
                    state_d = IDLE;
                end else if (bus.tick) begin
                    if (rcnt_q + 1'b1 == rpt_limit) begin
                        step_l  = dir_left_q;
                        step_r  = ~dir_left_q;
                        rcnt_d  = '0;
                        state_d = REPEAT;
                    end else begin
                        rcnt_d = rcnt_q + 1'b1;
                    end
                end
            end
            default: begin
                rcnt_d  = '0;
                state_d = IDLE;
            end
        endcase
`else
        step_l = press_l;
        step_r = press_r;
`endif
        // Bounds are tested before the +/-1 so the 4-bit value never wraps
        if (step_l && plrpos_q != POS_MIN_C) begin
            plrpos_d = plrpos_q - 1'b1;
            moved_d  = 1'b1;
        end else if (step_r && plrpos_q != POS_MAX_C) begin
            plrpos_d = plrpos_q + 1'b1;
            moved_d  = 1'b1;
        end
    end

    // State registers with synchronous active-low clear
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            prev_l_q   <= 1'b0;
            prev_r_q   <= 1'b0;
            plrpos_q   <= POS_RESET_C;
            moved_q    <= 1'b0;
`ifdef PLAYER_CTRL_AUTOREPEAT_EN
            state_q    <= IDLE;
            dir_left_q <= 1'b0;
            rcnt_q     <= '0;
`endif
        end else begin
            prev_l_q   <= prev_l_d;
            prev_r_q   <= prev_r_d;
            plrpos_q   <= plrpos_d;
            moved_q    <= moved_d;
`ifdef PLAYER_CTRL_AUTOREPEAT_EN
            state_q    <= state_d;
            dir_left_q <= dir_left_d;
            rcnt_q     <= rcnt_d;
`endif
        end
    end

    assign bus.plrpos = plrpos_q;
    assign bus.moved  = moved_q;

endmodule

// File: tb/tb_player_ctrl.sv
// Directed self-checking bench for player_ctrl (DB_CNT=4, RPT_DELAY=10, RPT_RATE=3).
// Tick strobes are one clk wide with two idle clks before each.
module tb_player_ctrl;
    import game_pkg::*;

    logic clk   = 1'b0;
    logic clr_n = 1'b0;
    always #5 clk = ~clk;

    player_ctrl_if bus ();

    player_ctrl #(
        .DB_CNT    (4),
        .POS_MIN   (0),
        .POS_MAX   (15),
        .POS_RESET (8),
        .RPT_DELAY (10),
        .RPT_RATE  (3)
    ) dut (
        .clk   (clk),
        .clr_n (clr_n),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;
    int moved_cnt = 0;
    bit moved_prev = 1'b0;
    bit consec = 1'b0;

    // Count moved pulses and flag any back-to-back pair
    always @(negedge clk) begin
        if (bus.moved === 1'b1) begin
            moved_cnt = moved_cnt + 1;
            if (moved_prev) consec = 1'b1;
        end
        moved_prev = (bus.moved === 1'b1);
    end

    task automatic tick_once();
        repeat (2) @(negedge clk);
        bus.tick = 1'b1;
        @(negedge clk);
        bus.tick = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick_once();
    endtask

    task automatic press(input bit left);
        if (left) bus.btn_left = 1'b1; else bus.btn_right = 1'b1;
        ticks(5);
        if (left) bus.btn_left = 1'b0; else bus.btn_right = 1'b0;
        ticks(5);
    endtask

    task automatic presses(input bit left, input int n);
        for (int i = 0; i < n; i++) press(left);
    endtask

    task automatic test_reset();
        int base;
        clr_n = 1'b0;
        bus.btn_left  = 1'b1;
        bus.btn_right = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.plrpos !== 4'd8) begin
            errors++;
            $display("FAIL reset_plrpos: got %0d expected 8", bus.plrpos);
        end
        checks++;
        if (bus.moved !== 1'b0) begin
            errors++;
            $display("FAIL reset_moved: got %b expected 0", bus.moved);
        end
        base = moved_cnt;
        bus.btn_left  = 1'b0;
        bus.btn_right = 1'b0;
        clr_n = 1'b1;
        ticks(6);
        checks++;
        if (bus.plrpos !== 4'd8 || moved_cnt != base) begin
            errors++;
            $display("FAIL reset_release: got pos %0d pulses %0d expected pos 8 pulses 0",
                     bus.plrpos, moved_cnt - base);
        end
    endtask

    task automatic test_bounce();
        int base;
        base = moved_cnt;
        for (int i = 0; i < 6; i++) begin
            bus.btn_right = (i % 2 == 0);
            tick_once();
        end
        bus.btn_right = 1'b1;
        ticks(3);
        checks++;
        if (bus.plrpos !== 4'd8 || moved_cnt != base) begin
            errors++;
            $display("FAIL bounce_early: got pos %0d pulses %0d expected pos 8 pulses 0",
                     bus.plrpos, moved_cnt - base);
        end
        tick_once();
        checks++;
        if (bus.moved !== 1'b0) begin
            errors++;
            $display("FAIL bounce_edge_cycle: moved %b expected 0", bus.moved);
        end
        @(negedge clk);
        checks++;
        if (bus.moved !== 1'b1 || bus.plrpos !== 4'd9) begin
            errors++;
            $display("FAIL bounce_step: got moved %b pos %0d expected moved 1 pos 9",
                     bus.moved, bus.plrpos);
        end
        bus.btn_right = 1'b0;
        ticks(6);
        checks++;
        if (bus.plrpos !== 4'd9 || moved_cnt - base != 1) begin
            errors++;
            $display("FAIL bounce_single: got pos %0d pulses %0d expected pos 9 pulses 1",
                     bus.plrpos, moved_cnt - base);
        end
    endtask

    task automatic test_saturation();
        int base;
        presses(1'b0, 6);
        checks++;
        if (bus.plrpos !== 4'd15) begin
            errors++;
            $display("FAIL sat_reach_max: got %0d expected 15", bus.plrpos);
        end
        base = moved_cnt;
        presses(1'b0, 3);
        checks++;
        if (bus.plrpos !== 4'd15 || moved_cnt != base) begin
            errors++;
            $display("FAIL sat_max: got pos %0d pulses %0d expected pos 15 pulses 0",
                     bus.plrpos, moved_cnt - base);
        end
        presses(1'b1, 15);
        checks++;
        if (bus.plrpos !== 4'd0) begin
            errors++;
            $display("FAIL sat_reach_min: got %0d expected 0", bus.plrpos);
        end
        base = moved_cnt;
        press(1'b1);
        checks++;
        if (bus.plrpos !== 4'd0 || moved_cnt != base) begin
            errors++;
            $display("FAIL sat_min: got pos %0d pulses %0d expected pos 0 pulses 0",
                     bus.plrpos, moved_cnt - base);
        end
    endtask

    task automatic test_simultaneous();
        int base;
        presses(1'b0, 3);
        checks++;
        if (bus.plrpos !== 4'd3) begin
            errors++;
            $display("FAIL simul_setup: got %0d expected 3", bus.plrpos);
        end
        base = moved_cnt;
        bus.btn_left  = 1'b1;
        bus.btn_right = 1'b1;
        ticks(20);
        checks++;
        if (bus.plrpos !== 4'd3 || moved_cnt != base) begin
            errors++;
            $display("FAIL simul_both: got pos %0d pulses %0d expected pos 3 pulses 0",
                     bus.plrpos, moved_cnt - base);
        end
        bus.btn_right = 1'b0;
        ticks(10);
        checks++;
        if (bus.plrpos !== 4'd3 || moved_cnt != base) begin
            errors++;
            $display("FAIL simul_release_right: got pos %0d pulses %0d expected pos 3 pulses 0",
                     bus.plrpos, moved_cnt - base);
        end
        bus.btn_left = 1'b0;
        ticks(6);
    endtask

    task automatic test_autorepeat();
        int base;
        int exp_pos;
        int exp_pulses;
`ifdef PLAYER_CTRL_AUTOREPEAT_EN
        exp_pos    = 3;
        exp_pulses = 5;
`else
        exp_pos    = 7;
        exp_pulses = 1;
`endif
        presses(1'b0, 5);
        checks++;
        if (bus.plrpos !== 4'd8) begin
            errors++;
            $display("FAIL rpt_setup: got %0d expected 8", bus.plrpos);
        end
        base = moved_cnt;
        bus.btn_left = 1'b1;
        ticks(4);
        @(negedge clk);
        checks++;
        if (bus.plrpos !== 4'd7) begin
            errors++;
            $display("FAIL rpt_first_step: got %0d expected 7", bus.plrpos);
        end
        ticks(20);
        checks++;
        if (int'(bus.plrpos) != exp_pos || moved_cnt - base != exp_pulses) begin
            errors++;
            $display("FAIL rpt_hold: got pos %0d pulses %0d expected pos %0d pulses %0d",
                     bus.plrpos, moved_cnt - base, exp_pos, exp_pulses);
        end
    endtask

    task automatic test_mid_reset();
        @(negedge clk);
        clr_n = 1'b0;
        @(negedge clk);
        clr_n = 1'b1;
        checks++;
        if (bus.plrpos !== 4'd8 || bus.moved !== 1'b0) begin
            errors++;
            $display("FAIL midreset_state: got pos %0d moved %b expected pos 8 moved 0",
                     bus.plrpos, bus.moved);
        end
        ticks(3);
        checks++;
        if (bus.plrpos !== 4'd8) begin
            errors++;
            $display("FAIL midreset_debounce: got %0d expected 8", bus.plrpos);
        end
        ticks(1);
        @(negedge clk);
        checks++;
        if (bus.plrpos !== 4'd7 || bus.moved !== 1'b1) begin
            errors++;
            $display("FAIL midreset_step: got pos %0d moved %b expected pos 7 moved 1",
                     bus.plrpos, bus.moved);
        end
        bus.btn_left = 1'b0;
        ticks(6);
    endtask

    task automatic test_back_to_back();
        checks++;
        if (consec) begin
            errors++;
            $display("FAIL moved_consecutive: got 1 expected 0");
        end
    endtask

    initial begin
        bus.tick      = 1'b0;
        bus.btn_left  = 1'b0;
        bus.btn_right = 1'b0;
        test_reset();
        test_bounce();
        test_saturation();
        test_simultaneous();
        test_autorepeat();
        test_mid_reset();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
